// File: rtl/sha3_padder.sv
// SHA-3 pad10*1 block builder: packs input beats into R-bit rate blocks; block valid the cycle after the accepting beat, input stalled while a block is held.
// Optional SHA3_PADDER_LENCNT_EN adds msg_bytes, the accepted byte count of the current/last message.
module sha3_padder #(
  parameter int          D        = 256,
  parameter int          IN_BYTES = 8,
  parameter logic [7:0]  DOMAIN   = 8'h06
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8*IN_BYTES-1:0]       in_data,
  input  logic [$clog2(IN_BYTES):0]   in_nbytes,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [1600-2*D-1:0]         blk_data,
  output logic                        blk_last,
  output logic                        blk_valid,
  input  logic                        blk_ready
`ifdef SHA3_PADDER_LENCNT_EN
  ,
  output logic [63:0]                 msg_bytes
`endif
);

  localparam int R  = 1600 - 2*D;
  localparam int RB = R / 8;
  localparam int PW = $clog2(RB + 1);

  typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [R-1:0]    blk_q, blk_d;
  logic            last_q, last_d;
  logic            pad_q, pad_d;
  logic            accept;
  int              cnt;
  int              p;

  assign accept = in_valid && in_ready;
  assign cnt    = in_last ? int'(in_nbytes) : IN_BYTES;
  assign p      = int'(ptr_q) + cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      ptr_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    blk_d   = blk_q;
    last_d  = last_q;
    pad_d   = pad_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          // Bytes past the valid count never land, so unwritten block bytes stay zero.
          for (int k = 0; k < IN_BYTES; k++) begin
            if (k < cnt && int'(ptr_q) + k < RB)
              blk_d[(int'(ptr_q) + k)*8 +: 8] = in_data[k*8 +: 8];
          end
          if (in_last) begin
            state_d = EMIT;
            ptr_d   = '0;
            if (p < RB) begin
              blk_d[p*8 +: 8] = blk_d[p*8 +: 8] ^ DOMAIN;
              blk_d[R-1 -: 8] = blk_d[R-1 -: 8] ^ 8'h80;
              last_d          = 1'b1;
            end else begin
              last_d = 1'b0;
              pad_d  = 1'b1;
            end
          end else if (p >= RB) begin
            state_d = EMIT;
            ptr_d   = '0;
            last_d  = 1'b0;
          end else begin
            ptr_d = PW'(p);
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          blk_d = '0;
          if (pad_q) begin
            // Message filled the block exactly: padding needs a block of its own.
            state_d         = PADBLK;
            blk_d[7:0]      = DOMAIN;
            blk_d[R-1 -: 8] = 8'h80;
            last_d          = 1'b1;
            pad_d           = 1'b0;
          end else begin
            state_d = FILL;
            last_d  = 1'b0;
          end
        end
      end
      PADBLK: begin
        if (blk_ready) begin
          state_d = FILL;
          blk_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready  = (state_q == FILL) && !reset;
  assign blk_valid = (state_q != FILL);
  assign blk_data  = blk_q;
  assign blk_last  = last_q;

`ifdef SHA3_PADDER_LENCNT_EN
  logic mid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_bytes <= '0;
      mid_q     <= 1'b0;
    end else if (accept) begin
      msg_bytes <= (mid_q ? msg_bytes : 64'd0) + 64'(cnt);
      mid_q     <= !in_last;
    end
  end
`endif

endmodule

// File: tb/tb_sha3_padder.sv
// Directed bench for sha3_padder: SHA3-256 instance with 8-byte beats, SHAKE-style 512 instance with 1-byte beats.
module tb_sha3_padder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [63:0]   a_in_data;
  logic [3:0]    a_in_nbytes;
  logic          a_in_last, a_in_valid, a_in_ready;
  logic [1087:0] a_blk_data;
  logic          a_blk_last, a_blk_valid, a_blk_ready;

  logic [7:0]    b_in_data;
  logic [0:0]    b_in_nbytes;
  logic          b_in_last, b_in_valid, b_in_ready;
  logic [575:0]  b_blk_data;
  logic          b_blk_last, b_blk_valid, b_blk_ready;

  int checks = 0;
  int failures = 0;
  logic [1087:0] exp_a;
  logic [575:0]  exp_b;

  sha3_padder #(.D(256), .IN_BYTES(8), .DOMAIN(8'h06)) dut_a (
    .clk(clk), .reset(reset),
    .in_data(a_in_data), .in_nbytes(a_in_nbytes), .in_last(a_in_last),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .blk_data(a_blk_data), .blk_last(a_blk_last), .blk_valid(a_blk_valid),
    .blk_ready(a_blk_ready)
  );

  sha3_padder #(.D(512), .IN_BYTES(1), .DOMAIN(8'h1F)) dut_b (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_nbytes(b_in_nbytes), .in_last(b_in_last),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .blk_data(b_blk_data), .blk_last(b_blk_last), .blk_valid(b_blk_valid),
    .blk_ready(b_blk_ready)
  );

  task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Message byte i has value base+i; unused lanes of the last beat carry EE to prove they are dropped.
  task automatic send_a(input int n, input int base);
    int nb;
    int cb;
    nb = (n == 0) ? 1 : (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      cb = (b == nb - 1) ? n - b*8 : 8;
      for (int k = 0; k < 8; k++)
        a_in_data[k*8 +: 8] = (k < cb) ? 8'(base + b*8 + k) : 8'hEE;
      a_in_nbytes = 4'(cb);
      a_in_last   = (b == nb - 1);
      a_in_valid  = 1'b1;
      if (b == 0 || b == nb - 1) begin
        chk("a_in_ready_fill", 1600'(a_in_ready), 1600'(1));
        chk("a_blk_valid_before_last", 1600'(a_blk_valid), 1600'(0));
      end
      tick();
    end
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic get_a(input string tag, input logic last_exp);
    for (int i = 0; i < 10 && a_blk_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, 1600'(a_blk_valid), 1600'(1));
    chk({tag, "_data"},  1600'(a_blk_data),  1600'(exp_a));
    chk({tag, "_last"},  1600'(a_blk_last),  1600'(last_exp));
    a_blk_ready = 1'b1;
    tick();
    a_blk_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_in_data = '0; a_in_nbytes = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_blk_ready = 1'b0;
    b_in_data = '0; b_in_nbytes = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_blk_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_a_in_ready",  1600'(a_in_ready),  1600'(0));
    chk("rst_b_in_ready",  1600'(b_in_ready),  1600'(0));
    chk("rst_a_blk_valid", 1600'(a_blk_valid), 1600'(0));
    chk("rst_a_blk_last",  1600'(a_blk_last),  1600'(0));
    chk("rst_a_blk_data",  1600'(a_blk_data),  1600'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_a_in_ready", 1600'(a_in_ready), 1600'(1));

    // Empty message.
    exp_a = '0; exp_a[7:0] = 8'h06; exp_a[1087 -: 8] = 8'h80;
    send_a(0, 0);
    chk("empty_latency", 1600'(a_blk_valid), 1600'(1));
    get_a("empty", 1'b1);
    chk("empty_valid_drop", 1600'(a_blk_valid), 1600'(0));

    // "abc".
    exp_a = '0;
    exp_a[7:0] = 8'h61; exp_a[15:8] = 8'h62; exp_a[23:16] = 8'h63; exp_a[31:24] = 8'h06;
    exp_a[1087 -: 8] = 8'h80;
    send_a(3, 'h61);
    chk("abc_latency", 1600'(a_blk_valid), 1600'(1));
    get_a("abc", 1'b1);

    // 135 bytes: pad lands in the last byte as 06|80, with a 5-cycle stall.
    exp_a = '0;
    for (int j = 0; j < 135; j++) exp_a[j*8 +: 8] = 8'(j + 1);
    exp_a[1087 -: 8] = 8'h86;
    send_a(135, 1);
    a_in_data = 64'h0123456789ABCDEF; a_in_nbytes = 4'd8; a_in_last = 1'b1; a_in_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid",    1600'(a_blk_valid), 1600'(1));
      chk("stall_in_ready", 1600'(a_in_ready),  1600'(0));
      chk("stall_data",     1600'(a_blk_data),  1600'(exp_a));
      tick();
    end
    a_in_valid = 1'b0; a_in_last = 1'b0;
    get_a("b135", 1'b1);
    chk("b135_valid_drop", 1600'(a_blk_valid), 1600'(0));
    chk("b135_resume_ready", 1600'(a_in_ready), 1600'(1));

    // 136 bytes: full data block, then a separate padding block.
    exp_a = '0;
    for (int j = 0; j < 136; j++) exp_a[j*8 +: 8] = 8'(j + 1);
    send_a(136, 1);
    get_a("b136_data_blk", 1'b0);
    chk("b136_pad_follow", 1600'(a_blk_valid), 1600'(1));
    exp_a = '0; exp_a[7:0] = 8'h06; exp_a[1087 -: 8] = 8'h80;
    get_a("b136_pad_blk", 1'b1);
    chk("b136_valid_drop", 1600'(a_blk_valid), 1600'(0));

    // Reset while a block is pending discards it.
    send_a(3, 'h61);
    chk("pend_valid", 1600'(a_blk_valid), 1600'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("pend_rst_valid", 1600'(a_blk_valid), 1600'(0));
    tick(); tick();
    chk("pend_rst_quiet", 1600'(a_blk_valid), 1600'(0));

    // SHAKE-domain instance: 3 bytes, reset mid-message, then an empty message.
    b_in_valid = 1'b1; b_in_last = 1'b0; b_in_nbytes = 1'b1;
    b_in_data = 8'hAA; tick();
    b_in_data = 8'hBB; tick();
    b_in_data = 8'hCC; tick();
    b_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("b_mid_rst_quiet", 1600'(b_blk_valid), 1600'(0));
    b_in_data = 8'h55; b_in_nbytes = 1'b0; b_in_last = 1'b1; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0; b_in_last = 1'b0;
    exp_b = '0; exp_b[7:0] = 8'h1F; exp_b[575 -: 8] = 8'h80;
    chk("b_empty_valid", 1600'(b_blk_valid), 1600'(1));
    chk("b_empty_data",  1600'(b_blk_data),  1600'(exp_b));
    chk("b_empty_last",  1600'(b_blk_last),  1600'(1));
    b_blk_ready = 1'b1;
    tick();
    b_blk_ready = 1'b0;
    chk("b_valid_drop", 1600'(b_blk_valid), 1600'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha3_padder.md
SHA3_PADDER -- requirements
Module: sha3_padder

Interface
REQ-001 SHALL have parameter D, default 256, meaning digest bits (224/256/384/512); rate R = 1600-2*D bits, RB = R/8 bytes.
REQ-002 SHALL have parameter IN_BYTES, default 8, meaning input bytes per beat (1/2/4/8; divides RB for every legal D).
REQ-003 SHALL have parameter DOMAIN, default 8'h06, meaning domain-separation byte (8'h06 SHA-3, 8'h1F SHAKE).
REQ-004 SHALL have ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8*IN_BYTES  message bytes, byte k at bits [8k+7:8k], byte 0 first.
- in_nbytes  input  clog2(IN_BYTES)+1  valid byte count on last beat (0..IN_BYTES); ignored otherwise.
- in_last  input  1  final beat of message.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat accepted when in_valid&in_ready.
- blk_data  output  R  padded rate block, block byte j at bits [8j+7:8j].
- blk_last  output  1  block is final block of message.
- blk_valid  output  1  block offered to keccak core.
- blk_ready  input  1  block consumed when blk_valid&blk_ready.

Function
REQ-005 SHALL implement states FILL, EMIT, PADBLK.
REQ-006 FILL: in_ready=1; each accepted beat writes its bytes at byte pointer ptr, ptr += IN_BYTES (non-last) or in_nbytes (last).
REQ-007 Non-last beats SHALL be full; in_nbytes ignored.
REQ-008 Non-last beat bringing ptr to RB -> EMIT next cycle, blk_last=0, ptr=0.
REQ-009 Last beat, final ptr p<RB -> byte p ^= DOMAIN, byte RB-1 ^= 8'h80, bytes p+1..RB-2 zero, EMIT next cycle, blk_last=1; p=RB-1 yields byte value DOMAIN|8'h80.
REQ-010 Last beat, final ptr = RB -> EMIT with blk_last=0, then PADBLK after handshake.
REQ-011 PADBLK: block = byte0 DOMAIN, byte RB-1 8'h80, rest zero, blk_valid=1, blk_last=1, in_ready=0.
REQ-012 EMIT/PADBLK: blk_valid=1, in_ready=0; blk_data, blk_last stable until handshake.
REQ-013 Handshake in EMIT(non-final) -> FILL or PADBLK; in EMIT(final)/PADBLK -> FILL, buffer zeroed; blk_valid low next cycle.
REQ-014 Latency: blk_valid SHALL rise the cycle after the accepting beat; no combinational path in_* -> blk_*.
REQ-015 Empty message (in_last, in_nbytes=0, ptr=0) SHALL yield one padded block per REQ-009.
REQ-016 Unused bytes of a last beat SHALL be discarded; bytes in a block never written SHALL be zero before padding.

Reset
REQ-017 reset SHALL force FILL, ptr=0, buffer zero, blk_valid=0, blk_last=0, in_ready=0 during reset, 1 the cycle after.
REQ-018 reset mid-message or during EMIT SHALL discard the partial/pending block; no blk_valid until new data.

Configuration
REQ-019 SHA3_PADDER_LENCNT_EN defined: extra output msg_bytes [63:0], count of accepted message bytes, zero on reset and on first beat of each message, final value held until next message starts.
REQ-020 Without SHA3_PADDER_LENCNT_EN: no msg_bytes port, no counter logic.

Verification
REQ-021 D=256, IN_BYTES=8: in_last, in_nbytes=0 -> one block: byte0=06, byte135=80, others 00, blk_last=1.
REQ-022 "abc" (61 62 63, nbytes=3, last) -> bytes0..3 = 61 62 63 06, byte135=80, blk_last=1.
REQ-023 135 bytes (16 full beats + nbytes=7) -> single block, byte134=last msg byte, byte135=86.
REQ-024 136 bytes (17 full beats, last on 17th) -> block A blk_last=0 all msg bytes, then block B byte0=06, byte135=80, blk_last=1.
REQ-025 blk_ready low 5 cycles during EMIT -> blk_data constant, in_ready=0 throughout; resumes after handshake.
REQ-026 DOMAIN=8'h1F, D=512, 3 bytes then reset mid-message, then empty message -> one block, byte0=1F, byte71=80; no stale data.
